// File: rtl/mux_rr_sel_scheduler_if.sv
// Bundle between the round-robin mux scheduler and its requesters/mux.
// The master modport is the scheduler side; the slave modport drives req and observes the select.
interface mux_rr_sel_scheduler_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0]         req;
    logic [$clog2(N_CH)-1:0] sel;
    logic [N_CH-1:0]         grant;
    logic                    valid;
    logic                    busy;

    modport master (
        input  req,
        output sel,
        output grant,
        output valid,
        output busy
    );

    modport slave (
        output req,
        input  sel,
        input  grant,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/mux_rr_sel_scheduler.sv
// Round-robin owner scheduler for an 8-to-1 mux with one dead cycle on every select change.
// Optional hold limit enabled by defining MUX_RR_HOLD_LIMIT_EN.
module mux_rr_sel_scheduler #(
    parameter int N_CH     = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux_rr_sel_scheduler_if.master  bus
);
    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t             state_reg,    state_next;
    logic [SEL_W-1:0]   sel_reg,      sel_next;
    logic [N_CH-1:0]    grant_reg,    grant_next;
    logic               valid_reg,    valid_next;
    logic [SEL_W-1:0]   last_ptr_reg, last_ptr_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;

    logic [SEL_W-1:0]   arb_base;
    logic [N_CH-1:0]    rot_req;
    logic [SEL_W-1:0]   arb_off;
    logic [SEL_W-1:0]   winner;
    logic               arb_any;
    logic [N_CH-1:0]    sel_onehot;
    logic               owner_req;
    logic               others_pending;
    logic               hold_limit_hit;

    // Requests rotated so that bit 0 is the requester just after the last owner.
    assign arb_base = last_ptr_reg + SEL_W'(1);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
            assign rot_req[gi]    = bus.req[arb_base + SEL_W'(gi)];
            assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        arb_off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                arb_off = SEL_W'(i);
            end
        end
    end

    assign arb_any        = |bus.req;
    assign winner         = arb_base + arb_off;
    assign owner_req      = |(bus.req & sel_onehot);
    assign others_pending = |(bus.req & ~sel_onehot);

`ifdef MUX_RR_HOLD_LIMIT_EN
    assign hold_limit_hit = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
`else
    assign hold_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            sel_reg      <= '0;
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            last_ptr_reg <= SEL_W'(N_CH - 1);
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            grant_reg    <= grant_next;
            valid_reg    <= valid_next;
            last_ptr_reg <= last_ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        grant_next    = grant_reg;
        valid_next    = valid_reg;
        last_ptr_next = last_ptr_reg;
        hold_cnt_next = hold_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    sel_next   = winner;
                    state_next = ST_GAP;
                end
            end

            // sel already points at the new owner; the mux settles this cycle.
            ST_GAP: begin
                if (owner_req) begin
                    state_next    = ST_GRANT;
                    grant_next    = sel_onehot;
                    valid_next    = 1'b1;
                    hold_cnt_next = '0;
                    last_ptr_next = sel_reg;
                end else if (arb_any) begin
                    sel_next = winner;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (hold_cnt_reg != CNT_W'(MAX_HOLD)) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
                // Owner drop takes precedence; both paths lead to the same place.
                if (!owner_req || (hold_limit_hit && others_pending)) begin
                    grant_next = '0;
                    valid_next = 1'b0;
                    if (others_pending) begin
                        sel_next   = winner;
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign bus.sel   = sel_reg;
    assign bus.grant = grant_reg;
    assign bus.valid = valid_reg;
    assign bus.busy  = (state_reg != ST_IDLE);

endmodule
